// File: rtl/ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_sequencer
// Description : Iterative RV32M multiply/divide controller for the execution
//               stage. Accepts one operation at a time, runs a 32-iteration
//               shift-add multiply or restoring divide on operand magnitudes,
//               applies sign correction and presents the result for one cycle.
//               The pipeline stall is held high while an operation is running.
//               Divide-by-zero and signed overflow finish in one cycle.
// Ports       :
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   operation request, sampled only in IDLE
//   op           in   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   operand_a    in   rs1 value (multiplicand / dividend)
//   operand_b    in   rs2 value (multiplier / divisor)
//   flush        in   synchronous abort
//   stall        out  freeze IF/ID/EX pipeline registers
//   busy         out  sequencer not idle
//   result_valid out  one-cycle result strobe
//   result       out  final result, held until overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam int c_cnt_w = $clog2(WIDTH);

  localparam logic [2:0] c_op_mul    = 3'd0;
  localparam logic [2:0] c_op_mulh   = 3'd1;
  localparam logic [2:0] c_op_mulhsu = 3'd2;
  localparam logic [2:0] c_op_mulhu  = 3'd3;
  localparam logic [2:0] c_op_div    = 3'd4;
  localparam logic [2:0] c_op_divu   = 3'd5;
  localparam logic [2:0] c_op_rem    = 3'd6;
  localparam logic [2:0] c_op_remu   = 3'd7;

  localparam logic [WIDTH-1:0] c_min_int = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_op;
  logic                 r_neg;      // negate product / quotient
  logic                 r_neg_rem;  // negate remainder (sign of dividend)
  logic [WIDTH-1:0]     r_hi;       // product high half / partial remainder
  logic [WIDTH-1:0]     r_lo;       // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0]     r_opnd;     // multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0]     r_result;

  // ---------------------------------------------------------------------------
  // Accept-time decode: which operands are interpreted as signed, their
  // magnitudes, and the one-cycle special cases.
  // ---------------------------------------------------------------------------
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_special_res;

  always_comb begin
    w_a_signed = (op == c_op_mulh) || (op == c_op_mulhsu) ||
                 (op == c_op_div)  || (op == c_op_rem);
    w_b_signed = (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
    w_sign_a   = w_a_signed & operand_a[WIDTH-1];
    w_sign_b   = w_b_signed & operand_b[WIDTH-1];
    w_mag_a    = w_sign_a ? -operand_a : operand_a;
    w_mag_b    = w_sign_b ? -operand_b : operand_b;
    w_div_zero = (operand_b == '0);
    w_div_ovf  = ((op == c_op_div) || (op == c_op_rem)) &&
                 (operand_a == c_min_int) && (operand_b == '1);
    w_special  = op[2] & (w_div_zero | w_div_ovf);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (w_div_zero) begin
      w_special_res = op[1] ? operand_a : '1;
    end else begin
      w_special_res = op[1] ? '0 : c_min_int;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of multiply or divide, computed from the current registers.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;

  always_comb begin
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // {carry, hi, lo} right by one so the low product bits fill r_lo.
    w_add   = {1'b0, r_hi} + ({1'b0, r_opnd} & {(WIDTH+1){r_lo[0]}});
    // Restoring divide: bring the next dividend bit into the remainder and
    // keep the subtraction only when it does not go negative.
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_opnd};
    w_qbit  = ~w_trial[WIDTH];
    if (r_op[2]) begin
      w_nxt_hi = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_nxt_lo = {r_lo[WIDTH-2:0], w_qbit};
    end else begin
      w_nxt_hi = w_add[WIDTH:1];
      w_nxt_lo = {w_add[0], r_lo[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign correction and result selection on the last iteration.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_final;

  always_comb begin
    w_prod   = {w_nxt_hi, w_nxt_lo};
    w_prod_s = r_neg ? -w_prod : w_prod;
    w_quo_s  = r_neg ? -w_nxt_lo : w_nxt_lo;
    w_rem_s  = r_neg_rem ? -w_nxt_hi : w_nxt_hi;
    case (r_op)
      c_op_mul:                           w_final = w_prod_s[WIDTH-1:0];
      c_op_mulh, c_op_mulhsu, c_op_mulhu: w_final = w_prod_s[2*WIDTH-1:WIDTH];
      c_op_div, c_op_divu:                w_final = w_quo_s;
      c_op_rem, c_op_remu:                w_final = w_rem_s;
      default:                            w_final = w_quo_s;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_result  <= '0;
    end else if (flush) begin
      // Abort wins over everything, including completion on the last
      // iteration; the previous result is left untouched.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_neg     <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= op[2] ? w_mag_a : w_mag_b;
              r_opnd  <= op[2] ? w_mag_b : w_mag_a;
              r_cnt   <= c_cnt_w'(WIDTH-1);
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_hi <= w_nxt_hi;
          r_lo <= w_nxt_lo;
          if (r_cnt == '0) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall asserts combinationally in the accept cycle so the requesting
  // instruction stays in EX; it drops in DONE so the result is captured.
  // Gated by rst so the pipeline is never frozen while in reset.
  assign stall        = rst & (((r_state == S_IDLE) & start & ~flush) |
                               (r_state == S_BUSY));
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_sequencer
// Description : Scoreboard bench for ex_muldiv_sequencer. The driver pushes
//               hand-computed results with their expected completion cycle;
//               an independent monitor pops and compares on result_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  ex_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && result_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid at cyc=%0d result=%h", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout busy=%b required=0", busy);
    end
  endtask

  // Issue one operation; returns once the sequencer is idle again.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    #1;
    chk("stall_on_request", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = exp;
    e.cyc = special ? cyc : cyc + 32;
    sb.push_back(e);
    wait_idle();
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; op = 3'd0; operand_a = '0; operand_b = '0; flush = 1'b0;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // MUL with stall held across all busy cycles
    begin
      int stall_cnt;
      exp_t e;
      stall_cnt = 0;
      wait_idle();
      start = 1'b1; op = 3'd0; operand_a = 32'd7; operand_b = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      start = 1'b0;
      e.res = 32'hFFFF_FFEB; e.cyc = cyc + 32;
      sb.push_back(e);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (stall) stall_cnt++;
      end
      chk("mul_stall_cycles", stall_cnt, 32);
    end

    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0); // MULH
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); // MULHU
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0); // MULHSU
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);         // DIV
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);         // REM
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);                      // DIVU
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0);                       // REMU
    do_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);              // DIVU /0
    do_op(3'd6, 32'h1234, 32'd0, 32'h0000_1234, 1'b1);              // REM /0
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);         // REM ovf
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); // DIV ovf

    // Flush at N+5 of a DIV: idle next cycle, no strobe, result kept
    wait_idle();
    start = 1'b1; op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_valid", {31'd0, result_valid}, 32'd0);
    chk("flush_result", result, 32'h8000_0000);
    repeat (40) @(negedge clk);

    // start during BUSY must be ignored
    fork
      do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1; op = 3'd0; operand_a = 32'd5; operand_b = 32'd5;
        repeat (4) @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);

    // Reset around cycle 10 of a DIV
    wait_idle();
    start = 1'b1; op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    start = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    chk("rstmid_valid", {31'd0, result_valid}, 32'd0);
    chk("rstmid_result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(3'd0, 32'd2, 32'd3, 32'd6, 1'b0);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
Iterative controller for RV32M multiply/divide operations issued to the execution stage. It accepts one operation at a time, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline stall high until the result is ready. The result is presented for one cycle and the execution stage muxes it onto alu_result_from_execution. Flush and reset abort any operation in progress.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported (iteration counter is $clog2(WIDTH) bits).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
operand_a  input  WIDTH  rs1 value (multiplicand / dividend)
operand_b  input  WIDTH  rs2 value (multiplier / divisor)
flush  input  1  synchronous abort from branch/exception logic
stall  output  1  freeze IF/ID/EX pipeline registers
busy  output  1  state != IDLE
result_valid  output  1  one-cycle strobe: result is valid
result  output  WIDTH  final result; held until the next accept

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, result 0, result_valid 0, busy 0, internal regs 0. Because stall is combinational, stall=0 while in reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE: start=1 and flush=0 at edge N accepts the operation and latches op, the operand signs and the operand magnitudes.
  - Signed magnitudes: MULH both operands; MULHSU operand_a only; DIV/REM both operands; MUL is treated as unsigned (low word is sign-agnostic).
  - Special cases go IDLE->DONE directly with the result precomputed:
    - divisor==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result operand_a.
    - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
  - Otherwise: counter=WIDTH-1, next state BUSY.
- BUSY: one iteration per cycle, 32 cycles total (N+1..N+32).
  - Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring divide; shift remainder:quotient left, trial-subtract divisor, set quotient bit if the result is non-negative.
  - When counter==0, apply sign correction and load result, then go to DONE.
  - Sign rules: product negated if the operand signs differ; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32].
- DONE: result_valid=1 for exactly one cycle, then IDLE. A start in DONE is ignored; the requester re-presents the request.
- Latency:
  - Normal operation accepted at edge N: result_valid high during cycle N+33.
  - Special case: result_valid high during cycle N+1.
- stall = (state==IDLE & start & ~flush) | (state==BUSY). stall is low in DONE so the pipeline advances and captures result in that same cycle.
- flush: from any state, next state IDLE; result_valid is not asserted; result retains its previous value. flush in IDLE blocks acceptance. flush has priority over counter==0 completion.
- start while BUSY/DONE: ignored; the operands are not re-latched.
- Reset asserted mid-operation: immediate return to IDLE, with all outputs at their reset values.
- Back-to-back: a new start can be accepted in the IDLE cycle immediately following DONE.

Test Plan:
- Reset mid-BUSY (cycle 10 of a DIV) -> immediately busy=0, stall=0, result_valid=0, result=0; a subsequent MUL 2*3 gives result 6.
- MUL a=7, b=0xFFFFFFFD -> stall high for cycles N..N+32, result_valid at N+33, result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> result 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU a=0x1234, b=0 -> result_valid at N+1, result 0xFFFFFFFF; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1.
- Flush at cycle N+5 of a DIV -> IDLE at N+6, stall=0, no result_valid, result unchanged; start asserted during BUSY is ignored (only one result_valid pulse).
